// File: rtl/mant_alu_seq.sv
// Sequential mantissa ALU: single-cycle ADD/SUB, radix-2 shift-add MUL with early termination.
// Optional MUL sticky flag enabled by defining MANT_ALU_SEQ_STICKY_EN.
module mant_alu_seq #(
    parameter int unsigned W = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic             swapped,
    output logic             sticky
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] result_q, result_d;
    logic           swapped_q, swapped_d;

    logic [W:0]     sum;
    logic [W:0]     diff;
    logic           b_gt_a;
    logic [2*W-1:0] acc_step;
    logic [W-1:0]   mplier_shift;
    logic           mul_last;

    always_comb begin
        sum          = {1'b0, a} + {1'b0, b};
        b_gt_a       = (b > a);
        diff         = b_gt_a ? {1'b0, b - a} : {1'b0, a - b};
        acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shift = mplier_q >> 1;
        // Finish on the edge whose shift empties the multiplier, so RUN lasts bit-length(b) edges.
        mul_last     = (state_q == RUN) && (mplier_shift == '0);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        swapped_d = swapped_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        2'b01: begin
                            result_d  = {{(W-1){1'b0}}, diff};
                            swapped_d = b_gt_a;
                            state_d   = DONE;
                        end
                        2'b10: begin
                            if (b == '0) begin
                                result_d  = '0;
                                swapped_d = 1'b0;
                                state_d   = DONE;
                            end else begin
                                acc_d    = '0;
                                mcand_d  = {{W{1'b0}}, a};
                                mplier_d = b;
                                state_d  = RUN;
                            end
                        end
                        default: begin
                            result_d  = {{(W-1){1'b0}}, sum};
                            swapped_d = 1'b0;
                            state_d   = DONE;
                        end
                    endcase
                end
            end
            RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                if (mul_last) begin
                    result_d  = acc_step;
                    swapped_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
            swapped_q <= swapped_d;
        end
    end

`ifdef MANT_ALU_SEQ_STICKY_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (mul_last) begin
            sticky_d = |acc_step[W-2:0];
        end else if ((state_q == IDLE) && start) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign result  = result_q;
    assign swapped = swapped_q;

endmodule

// File: doc/mant_alu_seq.md
MANT_ALU_SEQ -- requirements
Module: mant_alu_seq

Interface
REQ-001 Parameter W, default 28: operand width in bits, W >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 2'b00 ADD, 2'b01 SUB, 2'b10 MUL, 2'b11 reserved.
REQ-006 a  input  W  operand A, unsigned; multiplicand for MUL.
REQ-007 b  input  W  operand B, unsigned; multiplier for MUL.
REQ-008 busy  output  1  high while an operation is in RUN.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 result  output  2W  ADD/SUB: zero-extended W+1-bit value; MUL: full product.
REQ-011 swapped  output  1  SUB only: high when b > a.
REQ-012 sticky  output  1  MUL low-bit sticky flag (see Configuration).

Function
REQ-013 FSM states: IDLE, RUN, DONE. Edges are numbered from E0, the edge that samples start=1 in IDLE.
REQ-014 IDLE -> DONE at E0 for ADD, SUB, reserved op, and MUL with b==0.
REQ-015 IDLE -> RUN at E0 for MUL with b!=0; operands latched at E0.
REQ-016 DONE -> IDLE on the next edge unconditionally; done is high only in DONE.
REQ-017 ADD: result = a + b with carry in bit W, upper bits zero; valid in the cycle after E0.
REQ-018 SUB: result = |a - b|; swapped = (b > a); a == b gives result 0 and swapped 0.
REQ-019 Reserved op is treated as ADD.
REQ-020 MUL is radix-2 shift-add with a 2W accumulator, a 2W left-shifting multiplicand and a W right-shifting multiplier.
REQ-021 MUL, each RUN edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1.
REQ-022 MUL exits RUN on the edge where the shifted multiplier becomes 0 (early termination).
REQ-023 MUL RUN length is n = bit-length of b (1..W) edges; done is high after edge En.
REQ-024 MUL with b==0 gives result 0 after E0.
REQ-025 start is ignored in RUN and DONE; no queuing.
REQ-026 result, swapped and sticky hold their values from DONE until the next accepted start updates them.
REQ-027 Operand changes after E0 do not affect the operation in progress.
REQ-028 busy = (state == RUN).

Reset
REQ-029 reset (synchronous) forces IDLE with busy=0, done=0, result=0, swapped=0, sticky=0, and clears all internal registers.
REQ-030 reset has priority over start, and reset mid-RUN abandons the operation without asserting done.
REQ-031 A start that coincides with reset is dropped.

Configuration
REQ-032 Macro MANT_ALU_SEQ_STICKY_EN.
REQ-033 With MANT_ALU_SEQ_STICKY_EN defined: for MUL, sticky = OR of result[W-2:0] (bits below guard), latched with result; for other ops, sticky = 0.
REQ-034 Without MANT_ALU_SEQ_STICKY_EN: the sticky port exists but is tied to 0, with no reduction logic.

Verification (W=28)
REQ-035 ADD: a=0x0800000, b=0x0400000 -> done 1 cycle after E0, result=0xC00000, busy never high.
REQ-036 SUB: a=3, b=5 -> result=2, swapped=1; then a=b=7 -> result=0, swapped=0.
REQ-037 MUL: a=b=0xFFFFFFF -> busy for 28 cycles, done after E28, result=0xFFFFFFE0000001; with the macro, sticky=1.
REQ-038 MUL: a=0x1234, b=0 -> done after E0, result=0; then a=3, b=4 -> done after E3, result=12.
REQ-039 MUL: a=5, b=0xFFFFFFF -> at cycle 10 pulse start with op=ADD (ignored), then assert reset -> busy=0, result=0, no done; a fresh ADD completes normally.
REQ-040 Without the macro: MUL a=3, b=1 -> result=3, sticky=0; with the macro -> sticky=1.
